// File: rtl/wb_write_arbiter_if.sv
// Write-back port bundle for wb_write_arbiter: ALU/load sources in,
// register-file write port and hazard status out.
interface wb_write_arbiter_if #(
  parameter int PTR_W = 2
);
  logic             alu_valid;
  logic [4:0]       alu_rw;
  logic [31:0]      alu_data;
  logic             mem_valid;
  logic [4:0]       mem_rw;
  logic [31:0]      mem_data;
  logic             mem_ready;
  logic             RegWr;
  logic [4:0]       Rw;
  logic [31:0]      busW;
  logic [31:0]      pending_mask;
  logic [PTR_W:0]   fifo_count;

  modport master (
    output alu_valid, alu_rw, alu_data,
    output mem_valid, mem_rw, mem_data,
    input  mem_ready,
    input  RegWr, Rw, busW,
    input  pending_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rw, alu_data,
    input  mem_valid, mem_rw, mem_data,
    output mem_ready,
    output RegWr, Rw, busW,
    output pending_mask, fifo_count
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: ALU results beat queued loads.
// Optional load bypass on an empty FIFO: define WB_ARB_BYPASS_EN.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_arbiter_if.slave  bus
);
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  logic [4:0]       rw_q   [DEPTH];
  logic [4:0]       rw_d   [DEPTH];
  logic [31:0]      dat_q  [DEPTH];
  logic [31:0]      dat_d  [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  ptr_t             head_q, head_d;
  ptr_t             tail_q, tail_d;
  cnt_t             cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic [4:0]       rwo_q, rwo_d;
  logic [31:0]      bw_q, bw_d;
  logic [31:0]      pend_q, pend_d;

  logic alu_go;
  logic empty;
  logic full;
  logic mem_ok;
  logic mem_kill;
  logic bypass;
  logic pop;
  logic push;

  assign alu_go   = bus.alu_valid && (bus.alu_rw != 5'd0);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == cnt_t'(DEPTH));
  assign mem_ok   = bus.mem_valid && !full
                    && (bus.mem_rw != 5'd0);
  assign mem_kill = alu_go && (bus.mem_rw == bus.alu_rw);
  assign pop      = !alu_go && !empty;

`ifdef WB_ARB_BYPASS_EN
  assign bypass = !alu_go && empty && mem_ok;
`else
  assign bypass = 1'b0;
`endif

  assign push = mem_ok && !mem_kill && !bypass;

  always_comb begin
    rw_d   = rw_q;
    dat_d  = dat_q;
    live_d = live_q;
    head_d = head_q;
    tail_d = tail_q;
    wr_d   = 1'b0;
    rwo_d  = rwo_q;
    bw_d   = bw_q;

    // Younger ALU write supersedes queued loads to the same register
    if (alu_go) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (rw_q[i] == bus.alu_rw) live_d[i] = 1'b0;
      end
    end

    unique case (1'b1)
      alu_go: begin
        wr_d  = 1'b1;
        rwo_d = bus.alu_rw;
        bw_d  = bus.alu_data;
      end
      pop: begin
        wr_d = live_q[head_q];
        if (live_q[head_q]) begin
          rwo_d = rw_q[head_q];
          bw_d  = dat_q[head_q];
        end
      end
      bypass: begin
        wr_d  = 1'b1;
        rwo_d = bus.mem_rw;
        bw_d  = bus.mem_data;
      end
      default: ;
    endcase

    // Live bits are cleared on pop so live implies occupied
    if (pop) begin
      live_d[head_q] = 1'b0;
      head_d         = head_q + ptr_t'(1);
    end

    if (push) begin
      rw_d[tail_q]   = bus.mem_rw;
      dat_d[tail_q]  = bus.mem_data;
      live_d[tail_q] = 1'b1;
      tail_d         = tail_q + ptr_t'(1);
    end

    cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);

    pend_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_d[i]) pend_d[rw_d[i]] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      live_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      wr_q   <= 1'b0;
      rwo_q  <= '0;
      bw_q   <= '0;
      pend_q <= '0;
    end else begin
      live_q <= live_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      wr_q   <= wr_d;
      rwo_q  <= rwo_d;
      bw_q   <= bw_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    rw_q  <= rw_d;
    dat_q <= dat_d;
  end

  assign bus.mem_ready    = !full;
  assign bus.RegWr        = wr_q;
  assign bus.Rw           = rwo_q;
  assign bus.busW         = bw_q;
  assign bus.pending_mask = pend_q;
  assign bus.fifo_count   = cnt_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed vector bench for wb_write_arbiter (default build,
// load bypass not compiled in).
module tb_wb_write_arbiter;
  logic clk;
  logic rst;

  wb_write_arbiter_if #(.PTR_W(2)) bus ();

  wb_write_arbiter #(
    .DEPTH(4),
    .PTR_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] bw;
    logic        rdy;
    logic [2:0]  cnt;
    logic [31:0] pm;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic bad7   = 1'b0;

  always @(negedge clk) begin
    if (bus.RegWr && bus.Rw == 5'd7 && bus.busW == 32'h7777)
      bad7 = 1'b1;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(string nm, logic r,
                     logic av, logic [4:0] ar, logic [31:0] ad,
                     logic mv, logic [4:0] mr, logic [31:0] md,
                     logic wr, logic [4:0] rw, logic [31:0] bw,
                     logic rdy, logic [2:0] cnt, logic [31:0] pm);
    vec_t v;
    v.name = nm; v.rst = r;
    v.av = av; v.ar = ar; v.ad = ad;
    v.mv = mv; v.mr = mr; v.md = md;
    v.wr = wr; v.rw = rw; v.bw = bw;
    v.rdy = rdy; v.cnt = cnt; v.pm = pm;
    vecs.push_back(v);
  endtask

  task automatic drive(logic r, logic av, logic [4:0] ar,
                       logic [31:0] ad, logic mv, logic [4:0] mr,
                       logic [31:0] md);
    rst           = r;
    bus.alu_valid = av;
    bus.alu_rw    = ar;
    bus.alu_data  = ad;
    bus.mem_valid = mv;
    bus.mem_rw    = mr;
    bus.mem_data  = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    add("reset", 1, 0,0,0, 0,0,0, 0,0,0, 1,0,0);
    for (int i = 0; i < 5; i++)
      add("idle", 0, 0,0,0, 0,0,0, 0,0,0, 1,0,0);

    add("alu5",     0, 1,5,32'hDEADBEEF, 0,0,0,
        1,5,32'hDEADBEEF, 1,0,0);
    add("alu_drop", 0, 0,0,0, 0,0,0,
        0,5,32'hDEADBEEF, 1,0,0);

    add("cont0", 0, 1,10,32'hA0, 1,1,32'h11, 1,10,32'hA0, 1,1,32'h02);
    add("cont1", 0, 1,10,32'hA1, 1,2,32'h22, 1,10,32'hA1, 1,2,32'h06);
    add("cont2", 0, 1,10,32'hA2, 1,3,32'h33, 1,10,32'hA2, 1,3,32'h0E);
    add("cont3", 0, 1,10,32'hA3, 1,4,32'h44, 1,10,32'hA3, 0,4,32'h1E);
    add("cont4", 0, 1,10,32'hA4, 0,0,0,      1,10,32'hA4, 0,4,32'h1E);
    add("full_ign", 0, 1,10,32'hA5, 1,9,32'h99, 1,10,32'hA5, 0,4,32'h1E);
    add("pop_r1", 0, 0,0,0, 0,0,0,       1,1,32'h11, 1,3,32'h1C);
    add("pushpop",0, 0,0,0, 1,6,32'h66,  1,2,32'h22, 1,3,32'h58);
    add("pop_r3", 0, 0,0,0, 0,0,0,       1,3,32'h33, 1,2,32'h50);
    add("pop_r4", 0, 0,0,0, 0,0,0,       1,4,32'h44, 1,1,32'h40);
    add("pop_wrap",0, 0,0,0, 0,0,0,      1,6,32'h66, 1,0,32'h00);
    add("drain",  0, 0,0,0, 0,0,0,       0,6,32'h66, 1,0,32'h00);

    add("kill_q",  0, 0,0,0, 1,7,32'h7777, 0,6,32'h66, 1,1,32'h80);
    add("kill_alu",0, 1,7,32'h1234, 0,0,0, 1,7,32'h1234, 1,1,32'h00);
    add("kill_pop",0, 0,0,0, 0,0,0,        0,7,32'h1234, 1,0,32'h00);
    add("same_cyc",0, 1,8,32'h8888, 1,8,32'hBAD,
        1,8,32'h8888, 1,0,32'h00);
    add("same_idle",0, 0,0,0, 0,0,0,       0,8,32'h8888, 1,0,32'h00);

    add("r0_both", 0, 1,0,32'hFFFF, 1,0,32'hEEEE,
        0,8,32'h8888, 1,0,32'h00);
    add("r0_mem",  0, 0,0,0, 1,0,32'hEEEE, 0,8,32'h8888, 1,0,32'h00);
    add("q_r12",   0, 0,0,0, 1,12,32'hC,   0,8,32'h8888, 1,1,32'h1000);
    add("r0_alu_pop", 0, 1,0,32'hFF, 0,0,0, 1,12,32'hC, 1,0,32'h00);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].av, vecs[k].ar, vecs[k].ad,
            vecs[k].mv, vecs[k].mr, vecs[k].md);
      step();
      chk({vecs[k].name, ".RegWr"}, 32'(bus.RegWr), 32'(vecs[k].wr));
      chk({vecs[k].name, ".Rw"}, 32'(bus.Rw), 32'(vecs[k].rw));
      chk({vecs[k].name, ".busW"}, bus.busW, vecs[k].bw);
      chk({vecs[k].name, ".ready"}, 32'(bus.mem_ready),
          32'(vecs[k].rdy));
      chk({vecs[k].name, ".count"}, 32'(bus.fifo_count),
          32'(vecs[k].cnt));
      chk({vecs[k].name, ".pmask"}, bus.pending_mask, vecs[k].pm);
    end

    // Reset with three loads queued behind a busy ALU
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 5'd20, 32'hF0 + 32'(i),
            1'b1, 5'(11 + i), 32'hB0 + 32'(i));
      step();
    end
    chk("mid.count", 32'(bus.fifo_count), 32'd3);
    chk("mid.pmask", bus.pending_mask, 32'h0000_3800);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("rst.count", 32'(bus.fifo_count), 32'd0);
    chk("rst.pmask", bus.pending_mask, 32'h0);
    chk("rst.RegWr", 32'(bus.RegWr), 32'd0);
    chk("rst.Rw", 32'(bus.Rw), 32'd0);
    chk("rst.busW", bus.busW, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst.RegWr", 32'(bus.RegWr), 32'd0);
      chk("post_rst.count", 32'(bus.fifo_count), 32'd0);
    end

    chk("r7_never_7777", 32'(bad7), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
